// File: rtl/cistern_pump_ctrl.sv
// Cistern fill-pump controller: synchronizes and debounces the float switches,
// validates the thermometer code and runs the fill FSM with dry-run timeout.
module cistern_pump_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOW_LEVEL       = 2,
  parameter int HIGH_LEVEL      = 8,
  parameter int MAX_FILL_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] floater,
  input  logic       enable,
  input  logic       fault_clear,
  output logic       pump_on,
  output logic [3:0] level,
  output logic       level_valid,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [1:0] state
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMR_W = $clog2(MAX_FILL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MAX_FILL_CYCLES - 1);
  localparam logic [3:0] LOW_L  = 4'(LOW_LEVEL);
  localparam logic [3:0] HIGH_L = 4'(HIGH_LEVEL);
  localparam logic [3:0] LVL_ERR = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FILLING = 2'b01,
    ST_FULL    = 2'b10,
    ST_FAULT   = 2'b11
  } state_t;

  logic [7:0]       sync1, sync2, cand;
  logic [1:0]       sync_ok;
  logic             cand_ok;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       prev_level;
  logic [TMR_W-1:0] timer;
  state_t           st, nxt;
  logic             lvl_invalid, level_up, timeout;

  function automatic logic [3:0] decode(input logic [7:0] code);
    case (code)
      8'h00:   decode = 4'd0;
      8'h01:   decode = 4'd1;
      8'h03:   decode = 4'd2;
      8'h07:   decode = 4'd3;
      8'h0F:   decode = 4'd4;
      8'h1F:   decode = 4'd5;
      8'h3F:   decode = 4'd6;
      8'h7F:   decode = 4'd7;
      8'hFF:   decode = 4'd8;
      default: decode = LVL_ERR;
    endcase
  endfunction

  // Synchronizer plus debouncer. sync_ok/cand_ok make reset look like an input
  // change, so the first acceptance sees the same latency as any later one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= '0;
      sync2       <= '0;
      sync_ok     <= '0;
      cand        <= '0;
      cand_ok     <= 1'b0;
      cnt         <= '0;
      level       <= '0;
      level_valid <= 1'b0;
      prev_level  <= '0;
    end else begin
      // NOTE: non-blocking assignments let sync1 -> sync2 form a true two-stage pipeline.
      sync1      <= floater;
      sync2      <= sync1;
      sync_ok    <= {sync_ok[0], 1'b1};
      prev_level <= level;
      if (sync_ok[1]) begin
        if (!cand_ok || sync2 != cand) begin
          cand    <= sync2;
          cand_ok <= 1'b1;
          cnt     <= '0;
        end else if (cnt == CNT_LAST) begin
          level       <= decode(cand);
          level_valid <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign lvl_invalid = level_valid && (level == LVL_ERR);
  assign level_up    = (level != LVL_ERR) && (level > prev_level);
  assign timeout     = (st == ST_FILLING) && !level_up && (timer == TMR_LAST);

  // NOTE: nxt is assigned a default before any branch so no latch is inferred.
  always_comb begin
    nxt = st;
    if (lvl_invalid) begin
      nxt = ST_FAULT;
    end else if (timeout) begin
      nxt = ST_FAULT;
    end else begin
      case (st)
        ST_IDLE:    if (enable && level_valid && level <= LOW_L) nxt = ST_FILLING;
        ST_FILLING: if (level >= HIGH_L) nxt = ST_FULL;
                    else if (!enable) nxt = ST_IDLE;
        ST_FULL:    if (level <= LOW_L) nxt = ST_IDLE;
        ST_FAULT:   if (fault_clear) nxt = ST_IDLE;
        default:    nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from nxt so they change on the same edge as st.
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= ST_IDLE;
      pump_on    <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      timer      <= '0;
    end else begin
      st      <= nxt;
      pump_on <= (nxt == ST_FILLING);
      fault   <= (nxt == ST_FAULT);
      if (lvl_invalid)
        fault_code <= 2'b01;
      else if (timeout)
        fault_code <= 2'b10;
      else if (st == ST_FAULT && nxt == ST_IDLE)
        fault_code <= 2'b00;
      // A level drop while filling deliberately keeps the timer running.
      if (nxt == ST_FILLING && (st != ST_FILLING || level_up))
        timer <= '0;
      else if (st == ST_FILLING)
        timer <= timer + 1'b1;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_cistern_pump_ctrl.sv
// Directed bench for cistern_pump_ctrl: vector table for the fill cycle and
// fault clearing, hand sequences for reset latency, glitch, timeout and reset.
module tb_cistern_pump_ctrl;

  localparam logic [1:0] S_IDLE = 2'b00, S_FILL = 2'b01, S_FULL = 2'b10, S_FAULT = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] floater;
  logic       enable;
  logic       fault_clear;
  logic       pump_on;
  logic [3:0] level;
  logic       level_valid;
  logic       fault;
  logic [1:0] fault_code;
  logic [1:0] state;

  int tests_run = 0;
  int tests_failed = 0;

  cistern_pump_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .LOW_LEVEL(2),
    .HIGH_LEVEL(8),
    .MAX_FILL_CYCLES(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .floater(floater),
    .enable(enable),
    .fault_clear(fault_clear),
    .pump_on(pump_on),
    .level(level),
    .level_valid(level_valid),
    .fault(fault),
    .fault_code(fault_code),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] flt;
    logic       en;
    logic       clr;
    int         wait_cycles;
    logic [3:0] exp_level;
    logic [1:0] exp_state;
    logic       exp_pump;
    logic [1:0] exp_code;
  } vec_t;

  vec_t vecs[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Fill ramp, full, drain, refill, invalid pattern and fault clearing.
    vecs.push_back('{8'h01, 1'b1, 1'b0, 10, 4'd1, S_FILL, 1'b1, 2'b00});
    vecs.push_back('{8'h03, 1'b1, 1'b0, 10, 4'd2, S_FILL, 1'b1, 2'b00});
    vecs.push_back('{8'h07, 1'b1, 1'b0, 10, 4'd3, S_FILL, 1'b1, 2'b00});
    vecs.push_back('{8'h0F, 1'b1, 1'b0, 10, 4'd4, S_FILL, 1'b1, 2'b00});
    vecs.push_back('{8'h1F, 1'b1, 1'b0, 10, 4'd5, S_FILL, 1'b1, 2'b00});
    vecs.push_back('{8'h3F, 1'b1, 1'b0, 10, 4'd6, S_FILL, 1'b1, 2'b00});
    vecs.push_back('{8'h7F, 1'b1, 1'b0, 10, 4'd7, S_FILL, 1'b1, 2'b00});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 10, 4'd8, S_FULL, 1'b0, 2'b00});
    vecs.push_back('{8'h7F, 1'b1, 1'b0, 10, 4'd7, S_FULL, 1'b0, 2'b00});
    vecs.push_back('{8'h3F, 1'b1, 1'b0, 10, 4'd6, S_FULL, 1'b0, 2'b00});
    vecs.push_back('{8'h1F, 1'b1, 1'b0, 10, 4'd5, S_FULL, 1'b0, 2'b00});
    vecs.push_back('{8'h0F, 1'b1, 1'b0, 10, 4'd4, S_FULL, 1'b0, 2'b00});
    vecs.push_back('{8'h07, 1'b1, 1'b0, 10, 4'd3, S_FULL, 1'b0, 2'b00});
    vecs.push_back('{8'h03, 1'b1, 1'b0,  8, 4'd2, S_IDLE, 1'b0, 2'b00});
    vecs.push_back('{8'h03, 1'b1, 1'b0,  1, 4'd2, S_FILL, 1'b1, 2'b00});
    vecs.push_back('{8'h05, 1'b1, 1'b0, 10, 4'hE, S_FAULT, 1'b0, 2'b01});
    vecs.push_back('{8'h05, 1'b1, 1'b1,  3, 4'hE, S_FAULT, 1'b0, 2'b01});
    vecs.push_back('{8'h07, 1'b1, 1'b0, 10, 4'd3, S_FAULT, 1'b0, 2'b01});
    vecs.push_back('{8'h07, 1'b1, 1'b1,  1, 4'd3, S_IDLE, 1'b0, 2'b00});
    vecs.push_back('{8'h07, 1'b1, 1'b0,  5, 4'd3, S_IDLE, 1'b0, 2'b00});

    rst = 1'b1; floater = 8'h00; enable = 1'b1; fault_clear = 1'b0;
    tick(3);
    check("reset_state", {6'd0, state}, {6'd0, S_IDLE});
    check("reset_pump", {7'd0, pump_on}, 8'd0);
    check("reset_code", {6'd0, fault_code}, 8'd0);

    // First acceptance after reset lands on the 7th edge.
    rst = 1'b0;
    tick(6);
    check("first_accept_e6_valid", {7'd0, level_valid}, 8'd0);
    tick(1);
    check("first_accept_e7_valid", {7'd0, level_valid}, 8'd1);
    check("first_accept_e7_level", {4'd0, level}, 8'd0);
    check("first_accept_e7_state", {6'd0, state}, {6'd0, S_IDLE});
    tick(1);
    check("first_fill_state", {6'd0, state}, {6'd0, S_FILL});
    check("first_fill_pump", {7'd0, pump_on}, 8'd1);

    // Three-cycle glitch must never reach the accepted level.
    floater = 8'hFF;
    tick(3);
    floater = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check($sformatf("glitch_level_%0d", i), {4'd0, level}, 8'd0);
      check($sformatf("glitch_state_%0d", i), {6'd0, state}, {6'd0, S_FILL});
    end

    foreach (vecs[i]) begin
      floater = vecs[i].flt;
      enable = vecs[i].en;
      fault_clear = vecs[i].clr;
      tick(1);
      fault_clear = 1'b0;
      if (vecs[i].wait_cycles > 1) tick(vecs[i].wait_cycles - 1);
      check($sformatf("vec%0d_level", i), {4'd0, level}, {4'd0, vecs[i].exp_level});
      check($sformatf("vec%0d_state", i), {6'd0, state}, {6'd0, vecs[i].exp_state});
      check($sformatf("vec%0d_pump", i), {7'd0, pump_on}, {7'd0, vecs[i].exp_pump});
      check($sformatf("vec%0d_code", i), {6'd0, fault_code}, {6'd0, vecs[i].exp_code});
    end

    // Dry-run timeout: level frozen at 1 while filling.
    floater = 8'h01;
    tick(7);
    check("to_accept_level", {4'd0, level}, 8'd1);
    check("to_accept_state", {6'd0, state}, {6'd0, S_IDLE});
    tick(1);
    check("to_entry_state", {6'd0, state}, {6'd0, S_FILL});
    tick(31);
    check("to_before_state", {6'd0, state}, {6'd0, S_FILL});
    check("to_before_fault", {7'd0, fault}, 8'd0);
    tick(1);
    check("to_state", {6'd0, state}, {6'd0, S_FAULT});
    check("to_fault", {7'd0, fault}, 8'd1);
    check("to_code", {6'd0, fault_code}, 8'd2);
    check("to_pump", {7'd0, pump_on}, 8'd0);

    // Clear, refill, enable drop, then reset mid-fill.
    fault_clear = 1'b1;
    tick(1);
    fault_clear = 1'b0;
    check("clr_state", {6'd0, state}, {6'd0, S_IDLE});
    check("clr_code", {6'd0, fault_code}, 8'd0);
    tick(1);
    check("refill_state", {6'd0, state}, {6'd0, S_FILL});
    enable = 1'b0;
    tick(1);
    check("en_drop_state", {6'd0, state}, {6'd0, S_IDLE});
    check("en_drop_pump", {7'd0, pump_on}, 8'd0);
    enable = 1'b1;
    tick(1);
    check("en_back_pump", {7'd0, pump_on}, 8'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_mid_pump", {7'd0, pump_on}, 8'd0);
    check("rst_mid_level", {4'd0, level}, 8'd0);
    check("rst_mid_valid", {7'd0, level_valid}, 8'd0);
    check("rst_mid_state", {6'd0, state}, {6'd0, S_IDLE});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
